mioc_gate_seq: RTL and testbench

- On-chip exhaustive pattern sequencer/checker for a 3-input MIOC gate under test (e.g. mioc_nor3_nmos).
- Drives the gate inputs in1..in3 through all 8 vectors, waits a programmable settle time per vector, and samples z.
- Compares each z sample against a parameterised expected truth table; accumulates the error count and captures the first failing vector.
- Replaces file-driven pattern application for self-test on silicon.

---
 rtl/mioc_gate_seq_if.sv | 28 ++
 rtl/mioc_gate_seq.sv | 110 +++++++++++
 tb/tb_mioc_gate_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mioc_gate_seq_if.sv
// Handshake/result bundle between a sweep controller and the gate sequencer.
// Latency: none, plain wires.
// No backpressure: start is a level, results are held until restart.
interface mioc_gate_seq_if;
  logic       start;
  logic       z;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] fail_vec;

  // Controller side: requests sweeps, feeds back the gate output, reads results.
  modport master (
    output start, z,
    input  in1, in2, in3, busy, done, pass, err_count, fail_valid, fail_vec
  );

  // Sequencer side.
  modport slave (
    input  start, z,
    output in1, in2, in3, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/mioc_gate_seq.sv
// Exhaustive 3-input gate sweep: drives vectors 0..7, samples z after SETTLE cycles, checks EXP_TT.
// Latency: done rises 8*(SETTLE+1) cycles after the start edge; each vector held SETTLE+1 cycles.
// No backpressure: start is sampled only in IDLE/DONE and ignored while busy.
module mioc_gate_seq #(
  parameter int unsigned SETTLE = 4,
  parameter logic [7:0]  EXP_TT = 8'h01
) (
  input logic            clk,
  input logic            rst,
  mioc_gate_seq_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;     // also the driven gate inputs {in1,in2,in3}
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [2:0] fvec_q, fvec_d;
  logic       mismatch;

  // State and datapath registers; reset abandons any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  // Next-state: start from IDLE/DONE, count out the settle time, sample once per vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_SETTLE;
      S_SETTLE:       if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = (vec_q == 3'd7) ? S_DONE : S_SETTLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values: clear results on start, accumulate mismatches in SAMPLE.
  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    mismatch = bus.z != EXP_TT[vec_q];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          vec_d  = 3'd0;
          cnt_d  = 8'd0;
          err_d  = 4'd0;
          fv_d   = 1'b0;
          fvec_d = 3'd0;
        end
      end
      S_SETTLE: cnt_d = cnt_q + 8'd1;
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        // Last vector stays on the pins once the sweep finishes.
        if (vec_q != 3'd7) begin
          vec_d = vec_q + 3'd1;
          cnt_d = 8'd0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state; pass is only meaningful once done.
  always_comb begin
    bus.in1        = vec_q[2];
    bus.in2        = vec_q[1];
    bus.in3        = vec_q[0];
    bus.busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    bus.done       = (state_q == S_DONE);
    bus.pass       = (state_q == S_DONE) && (err_q == 4'd0);
    bus.err_count  = err_q;
    bus.fail_valid = fv_q;
    bus.fail_vec   = fvec_q;
  end

endmodule

// File: tb/tb_mioc_gate_seq.sv
// Bench for mioc_gate_seq: default NOR3 instance plus two SETTLE=1 NAND3 instances.
// Latency checked: done at start edge + 8*(SETTLE+1).
// No backpressure; start pulses applied from IDLE/DONE and while busy.
module tb_mioc_gate_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] st  = 3'b000;
  logic [1:0] zmode = 2'd0;   // dut 0 gate model: 0 NOR3, 1 stuck-at-0, 2 stuck-at-1

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mioc_gate_seq_if b0 ();
  mioc_gate_seq_if b1 ();
  mioc_gate_seq_if b2 ();

  assign b0.start = st[0];
  assign b1.start = st[1];
  assign b2.start = st[2];

  always_comb b0.z = (zmode == 2'd0) ? ~(b0.in1 | b0.in2 | b0.in3) : (zmode == 2'd2);
  always_comb b1.z = ~(b1.in1 & b1.in2 & b1.in3);
  always_comb b2.z = ~(b2.in1 & b2.in2 & b2.in3);

  mioc_gate_seq dut0 (.clk(clk), .rst(rst), .bus(b0));
  mioc_gate_seq #(.SETTLE(1), .EXP_TT(8'h7F)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mioc_gate_seq #(.SETTLE(1), .EXP_TT(8'h5F)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [1:0] mode;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
  } rec_t;

  rec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {in1,in2,in3, busy, done, pass, err_count, fail_valid, fail_vec}
  function automatic logic [13:0] get_all(input int d);
    case (d)
      0: return {b0.in1, b0.in2, b0.in3, b0.busy, b0.done, b0.pass, b0.err_count, b0.fail_valid, b0.fail_vec};
      1: return {b1.in1, b1.in2, b1.in3, b1.busy, b1.done, b1.pass, b1.err_count, b1.fail_valid, b1.fail_vec};
      default: return {b2.in1, b2.in2, b2.in3, b2.busy, b2.done, b2.pass, b2.err_count, b2.fail_valid, b2.fail_vec};
    endcase
  endfunction

  function automatic logic [2:0] f_in(input logic [13:0] a);   return a[13:11]; endfunction
  function automatic logic       f_busy(input logic [13:0] a); return a[10];    endfunction
  function automatic logic       f_done(input logic [13:0] a); return a[9];     endfunction
  function automatic logic       f_pass(input logic [13:0] a); return a[8];     endfunction
  function automatic logic [3:0] f_err(input logic [13:0] a);  return a[7:4];   endfunction
  function automatic logic       f_fv(input logic [13:0] a);   return a[3];     endfunction
  function automatic logic [2:0] f_fvec(input logic [13:0] a); return a[2:0];   endfunction

  // Pulse start on dut d, then follow the sweep edge by edge until done.
  // extra > 0 re-pulses start at that edge after E0 (must be ignored while busy).
  task automatic run_sweep(input int d, input int period, input int extra,
                           output int done_cyc, output int seq_bad, output logic start_ok);
    logic [13:0] a;
    int          expv;
    done_cyc = -1;
    seq_bad  = 0;
    @(negedge clk);
    st[d] = 1'b1;
    @(posedge clk);                       // E0
    #1 st[d] = 1'b0;
    a = get_all(d);
    start_ok = (f_in(a) == 3'd0) && f_busy(a) && !f_done(a) && (f_err(a) == 4'd0) &&
               !f_fv(a) && (f_fvec(a) == 3'd0);
    for (int k = 1; k <= 8 * period + 20; k++) begin
      if (k == extra) st[d] = 1'b1;
      @(posedge clk);
      #1 st[d] = 1'b0;
      a = get_all(d);
      expv = k / period;
      if (expv > 7) expv = 7;
      if (f_in(a) != expv[2:0]) seq_bad++;
      if (f_done(a)) begin
        done_cyc = k;
        if (f_busy(a)) seq_bad++;
        break;
      end
      if (!f_busy(a)) seq_bad++;
    end
  endtask

  int          dc, sb;
  logic        sok;
  logic [13:0] a;

  initial begin
    tbl[0] = '{mode: 2'd0, err: 4'd0, fv: 1'b0, fvec: 3'd0, pass: 1'b1};
    tbl[1] = '{mode: 2'd1, err: 4'd1, fv: 1'b1, fvec: 3'd0, pass: 1'b0};
    tbl[2] = '{mode: 2'd2, err: 4'd7, fv: 1'b1, fvec: 3'd1, pass: 1'b0};
    tbl[3] = '{mode: 2'd0, err: 4'd0, fv: 1'b0, fvec: 3'd0, pass: 1'b1};

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("reset_all_d%0d", d), 32'(get_all(d)), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_no_start", 32'(get_all(0)), 32'd0);

    // NOR3 instance under healthy and stuck gate models; each restart is from DONE.
    for (int i = 0; i < 4; i++) begin
      zmode = tbl[i].mode;
      run_sweep(0, 5, 0, dc, sb, sok);
      chk($sformatf("t%0d_start_clear", i), 32'(sok), 32'd1);
      chk($sformatf("t%0d_done_cycle", i), 32'(dc), 32'd40);
      chk($sformatf("t%0d_vec_seq", i), 32'(sb), 32'd0);
      repeat (3) @(posedge clk);
      #1 a = get_all(0);
      chk($sformatf("t%0d_done_held", i), 32'(f_done(a)), 32'd1);
      chk($sformatf("t%0d_in_final", i), 32'(f_in(a)), 32'd7);
      chk($sformatf("t%0d_err", i), 32'(f_err(a)), 32'(tbl[i].err));
      chk($sformatf("t%0d_fail_valid", i), 32'(f_fv(a)), 32'(tbl[i].fv));
      chk($sformatf("t%0d_fail_vec", i), 32'(f_fvec(a)), 32'(tbl[i].fvec));
      chk($sformatf("t%0d_pass", i), 32'(f_pass(a)), 32'(tbl[i].pass));
    end

    // Reset at E0+15 in the middle of a failing sweep.
    zmode = 2'd2;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1 chk("midrst_partial_err", 32'(b0.err_count), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_all_zero", 32'(get_all(0)), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_stays_idle", 32'(get_all(0)), 32'd0);
    zmode = 2'd0;
    run_sweep(0, 5, 0, dc, sb, sok);
    chk("postrst_done_cycle", 32'(dc), 32'd40);
    chk("postrst_pass", 32'(b0.pass), 32'd1);

    // Start pulsed at E0+10 while busy must not restart the sweep.
    run_sweep(0, 5, 10, dc, sb, sok);
    chk("busy_start_done_cycle", 32'(dc), 32'd40);
    chk("busy_start_vec_seq", 32'(sb), 32'd0);
    chk("busy_start_pass", 32'(b0.pass), 32'd1);

    // SETTLE=1, NAND3 truth table.
    run_sweep(1, 2, 0, dc, sb, sok);
    a = get_all(1);
    chk("nand_done_cycle", 32'(dc), 32'd16);
    chk("nand_vec_seq", 32'(sb), 32'd0);
    chk("nand_pass", 32'(f_pass(a)), 32'd1);
    chk("nand_err", 32'(f_err(a)), 32'd0);

    // SETTLE=1, NAND3 gate against a table with bit 5 inverted.
    run_sweep(2, 2, 0, dc, sb, sok);
    a = get_all(2);
    chk("nandx_done_cycle", 32'(dc), 32'd16);
    chk("nandx_err", 32'(f_err(a)), 32'd1);
    chk("nandx_fail_valid", 32'(f_fv(a)), 32'd1);
    chk("nandx_fail_vec", 32'(f_fvec(a)), 32'd5);
    chk("nandx_pass", 32'(f_pass(a)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
